// File: rtl/lut_lookup_arbiter_pkg.sv
// Shared sizing and helpers for the lookup-table forward-port arbiter.
// CHANNEL_NUM normally comes from the codebase's squart headers. The fallback below
// keeps this slice self-contained when those headers are not included first.
`ifndef CHANNEL_NUM
`define CHANNEL_NUM 4
`endif

package lut_lookup_arbiter_pkg;

   localparam int unsigned LUT_AW   = 8;
   localparam int unsigned LUT_DW   = 12 + `CHANNEL_NUM;
   localparam int unsigned STAT_W   = 16;
   localparam int unsigned NREQ_DEF = 4;

   // Saturating increment for the statistics counter.
   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (&v) ? v : v + STAT_W'(1);
   endfunction

endpackage

// File: rtl/lut_lookup_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter. It searches upward from ptr, wrapping modulo NREQ.
// Ports:
//   req   in  NREQ  request vector
//   ptr   in  IW    highest-priority index for this cycle
//   grant out NREQ  one-hot grant, or 0 when there is no request
//   idx   out IW    encoded index of the grant, or 0 when there is no request
module lut_lookup_arbiter_rr_arbiter #(
   parameter int unsigned NREQ = 4
) (
   input  logic [NREQ-1:0]                            req,
   input  logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] ptr,
   output logic [NREQ-1:0]                            grant,
   output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] idx
);

   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic found;

   // The first requester at rotating offset 0..NREQ-1 from ptr wins.
   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      for (int unsigned off = 0; off < NREQ; off++) begin
         for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (i == ((32'(ptr) + off) % NREQ))) begin
               grant[i] = 1'b1;
               idx      = IW'(i);
               found    = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/lut_lookup_arbiter.sv
// Round-robin sharing of the lookup table's single forward read port among NREQ
// requesters. Read data is registered and returned one cycle after the grant.
// Configuration: define LUT_WR_BYPASS_EN so that a host write to the granted address in
// the grant cycle forwards the new data. Without it, the pre-write entry is returned.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   req_valid/addr     per-requester lookup request (addr packed, requester i at [i*AW +: AW])
//   req_ready          one-hot combinational grant
//   lut_hold           suppresses new grants
//   rsp_valid/data     one-hot response strobe and entry, one cycle after the grant
//   fwd_rden/addr      forward read port to the table (combinational)
//   fwd_rdata          combinational read data from the table
//   host_wren/addr/wdata  snooped host write port
//   stat_lookups       saturating count of grants
module lut_lookup_arbiter
   import lut_lookup_arbiter_pkg::*;
#(
   parameter int unsigned NREQ = NREQ_DEF,
   parameter int unsigned AW   = LUT_AW,
   parameter int unsigned DW   = LUT_DW
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*AW-1:0]   req_addr,
   output logic [NREQ-1:0]      req_ready,
   input  logic                 lut_hold,
   output logic [NREQ-1:0]      rsp_valid,
   output logic [DW-1:0]        rsp_data,
   output logic                 fwd_rden,
   output logic [AW-1:0]        fwd_addr,
   input  logic [DW-1:0]        fwd_rdata,
   input  logic                 host_wren,
   input  logic [AW-1:0]        host_addr,
   input  logic [DW-1:0]        host_wdata,
   output logic [STAT_W-1:0]    stat_lookups
);

   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [IW-1:0]   rr_ptr;
   logic [NREQ-1:0] req_gated;
   logic [NREQ-1:0] grant;
   logic [IW-1:0]   grant_idx;
   logic [DW-1:0]   lookup_data;

   // Hold and reset block the arbiter inputs, so req_ready never feeds back on itself.
   assign req_gated = (rst_n && !lut_hold) ? req_valid : '0;

   lut_lookup_arbiter_rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
      .req   (req_gated),
      .ptr   (rr_ptr),
      .grant (grant),
      .idx   (grant_idx)
   );

   assign req_ready = grant;
   assign fwd_rden  = |grant;

   // Address mux. The one-hot grant lets a plain OR select the address, which is 0 when idle.
   always_comb begin
      fwd_addr = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            fwd_addr = fwd_addr | req_addr[i*AW +: AW];
         end
      end
   end

`ifdef LUT_WR_BYPASS_EN
   // A same-cycle host write to the looked-up entry wins over the stale table read.
   assign lookup_data = (host_wren && (host_addr == fwd_addr)) ? host_wdata : fwd_rdata;
`else
   logic unused_host;
   assign unused_host = ^{host_wren, host_addr, host_wdata};
   assign lookup_data = fwd_rdata;
`endif

   // Response register, rotating pointer and statistics counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr       <= '0;
         rsp_valid    <= '0;
         rsp_data     <= '0;
         stat_lookups <= '0;
      end else begin
         rsp_valid <= grant;
         if (|grant) begin
            rsp_data     <= lookup_data;
            rr_ptr       <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + IW'(1);
            stat_lookups <= sat_inc(stat_lookups);
         end
      end
   end

endmodule
